// File: rtl/pe_fp8_mac_pipe.sv
// Systolic FP8 MAC processing element: LANES FP8 products per beat, reduced to
// BF16 and accumulated with round-to-nearest-even; operands forwarded east/south.
module pe_fp8_mac_pipe #(
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 clear,
    input  logic                 fmt,
    input  logic [8*LANES-1:0]   a_in,
    input  logic [8*LANES-1:0]   b_in,
    output logic [8*LANES-1:0]   a_out,
    output logic [8*LANES-1:0]   b_out,
    output logic                 fwd_valid,
    output logic [15:0]          c_out,
    output logic                 c_valid
);

    // Lanes are padded to a power of two with zero operands, whose products are +0.
    localparam int NP = (LANES <= 1) ? 1 : (LANES <= 2) ? 2 : (LANES <= 4) ? 4 : 8;
    localparam int PW = 8 * NP;

    // Returns {nan, bf16}. Products are exact: at most 8 significant bits.
    function automatic logic [16:0] fp8_mul(input logic f, input logic [7:0] a, input logic [7:0] b);
        logic [4:0]  ea, eb;
        logic [2:0]  ma, mb;
        logic        za, zb, ia, ib, na, nb, s;
        logic [7:0]  p, e;
        logic [16:0] r;
        s = a[7] ^ b[7];
        if (f) begin
            ea = a[6:2];
            eb = b[6:2];
            ma = {a[1:0], 1'b0};
            mb = {b[1:0], 1'b0};
            ia = (ea == 5'd31) && (ma == 3'd0);
            ib = (eb == 5'd31) && (mb == 3'd0);
            na = (ea == 5'd31) && (ma != 3'd0);
            nb = (eb == 5'd31) && (mb != 3'd0);
        end else begin
            ea = {1'b0, a[6:3]};
            eb = {1'b0, b[6:3]};
            ma = a[2:0];
            mb = b[2:0];
            ia = 1'b0;
            ib = 1'b0;
            na = (a[6:0] == 7'h7F);
            nb = (b[6:0] == 7'h7F);
        end
        za = (ea == 5'd0);
        zb = (eb == 5'd0);
        p  = {4'd0, 1'b1, ma} * {4'd0, 1'b1, mb};
        e  = {3'd0, ea} + {3'd0, eb} + (f ? 8'd97 : 8'd113) + {7'd0, p[7]};
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = {1'b1, 16'h0000};
        end else if (ia || ib) begin
            r = {1'b0, s, 8'hFF, 7'h00};
        end else if (za || zb) begin
            r = {1'b0, s, 15'h0000};
        end else begin
            r = {1'b0, s, e, (p[7] ? p[6:0] : {p[5:0], 1'b0})};
        end
        return r;
    endfunction

    // Returns {nan, bf16}; guard/round/sticky alignment, RNE, flush-to-zero, Inf on overflow.
    function automatic logic [16:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
        logic              sl, ss, found;
        logic [7:0]        el, es, ml, ms, d, mant;
        logic [4:0]        dcap;
        logic [31:0]       shifted;
        logic [10:0]       mlx, msx, n;
        logic [11:0]       sum;
        logic [3:0]        lz;
        logic signed [9:0] e_n;
        logic              rnd;
        logic [16:0]       res;
        res = 17'h00000;
        if (((x[14:7] == 8'hFF) && (x[6:0] != 7'h00)) || ((y[14:7] == 8'hFF) && (y[6:0] != 7'h00))) begin
            res = {1'b1, 16'h7FC0};
        end else if ((x[14:7] == 8'hFF) && (y[14:7] == 8'hFF)) begin
            res = (x[15] != y[15]) ? {1'b1, 16'h7FC0} : {1'b0, x};
        end else if (x[14:7] == 8'hFF) begin
            res = {1'b0, x};
        end else if (y[14:7] == 8'hFF) begin
            res = {1'b0, y};
        end else if ((x[14:7] == 8'h00) && (y[14:7] == 8'h00)) begin
            res = {1'b0, x[15] & y[15], 15'h0000};
        end else if (x[14:7] == 8'h00) begin
            res = {1'b0, y};
        end else if (y[14:7] == 8'h00) begin
            res = {1'b0, x};
        end else begin
            if (x[14:0] >= y[14:0]) begin
                sl = x[15]; el = x[14:7]; ml = {1'b1, x[6:0]};
                ss = y[15]; es = y[14:7]; ms = {1'b1, y[6:0]};
            end else begin
                sl = y[15]; el = y[14:7]; ml = {1'b1, y[6:0]};
                ss = x[15]; es = x[14:7]; ms = {1'b1, x[6:0]};
            end
            d       = el - es;
            dcap    = (d > 8'd31) ? 5'd31 : d[4:0];
            shifted = {ms, 24'h000000} >> dcap;
            mlx     = {ml, 3'b000};
            msx     = {shifted[31:22], |shifted[21:0]};
            e_n     = $signed({2'b00, el});
            if (sl == ss) begin
                sum = {1'b0, mlx} + {1'b0, msx};
                if (sum[11]) begin
                    n   = {sum[11:2], sum[1] | sum[0]};
                    e_n = e_n + 10'sd1;
                end else begin
                    n = sum[10:0];
                end
            end else begin
                sum   = {1'b0, mlx - msx};
                n     = sum[10:0];
                lz    = 4'd0;
                found = 1'b0;
                for (int i = 10; i >= 0; i--) begin
                    if (!found && n[i]) begin
                        lz    = 4'(10 - i);
                        found = 1'b1;
                    end
                end
                n   = n << lz;
                e_n = e_n - $signed({6'd0, lz});
            end
            rnd  = n[2] & (n[1] | n[0] | n[3]);
            mant = {1'b0, n[9:3]} + {7'd0, rnd};
            if (mant[7]) begin
                e_n = e_n + 10'sd1;
            end else begin
                e_n = e_n;
            end
            if (n == 11'd0) begin
                res = 17'h00000;
            end else if (e_n <= 10'sd0) begin
                res = {1'b0, sl, 15'h0000};
            end else if (e_n >= 10'sd255) begin
                res = {1'b0, sl, 8'hFF, 7'h00};
            end else begin
                res = {1'b0, sl, e_n[7:0], mant[6:0]};
            end
        end
        return res;
    endfunction

    logic [PW-1:0] a_pad_s, b_pad_s;
    logic [16:0]   mul_s [NP];
    logic          prod_nan_s;
    logic [15:0]   s1_prod_r [NP];
    logic          s1_valid_r, s1_clear_r, s1_nan_r;
    logic [15:0]   node_s [2*NP-1];
    logic [16:0]   tadd_s;
    logic          tree_nan_s;
    logic [15:0]   s2_sum_r;
    logic          s2_valid_r, s2_clear_r, s2_nan_r;
    logic [15:0]   acc_r, acc_nxt_s;
    logic [16:0]   acc_add_s;
    logic          nan_r, nan_nxt_s;

    assign a_pad_s = PW'(a_in);
    assign b_pad_s = PW'(b_in);

    // Lane products and the beat's product NaN tag
    always_comb begin
        prod_nan_s = 1'b0;
        for (int i = 0; i < NP; i++) begin
            mul_s[i]   = fp8_mul(fmt, a_pad_s[8*i +: 8], b_pad_s[8*i +: 8]);
            prod_nan_s = prod_nan_s | mul_s[i][16];
        end
    end

    // Balanced adder tree over S1 products, heap-indexed with leaves at NP-1..2NP-2
    always_comb begin
        tree_nan_s = 1'b0;
        tadd_s     = 17'h00000;
        for (int i = 0; i < NP; i++) begin
            node_s[NP-1+i] = s1_prod_r[i];
        end
        for (int i = NP - 2; i >= 0; i--) begin
            tadd_s     = bf16_add(node_s[2*i+1], node_s[2*i+2]);
            node_s[i]  = tadd_s[15:0];
            tree_nan_s = tree_nan_s | tadd_s[16];
        end
    end

    // Accumulator next state: a clearing beat replaces value and NaN flag
    always_comb begin
        acc_add_s = bf16_add(acc_r, s2_sum_r);
        if (s2_clear_r) begin
            acc_nxt_s = s2_sum_r;
            nan_nxt_s = s2_nan_r;
        end else begin
            acc_nxt_s = acc_add_s[15:0];
            nan_nxt_s = nan_r | s2_nan_r | acc_add_s[16];
        end
    end

    // Forwarding, pipeline stages and accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out      <= '0;
            b_out      <= '0;
            fwd_valid  <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                s1_prod_r[i] <= 16'h0000;
            end
            s1_valid_r <= 1'b0;
            s1_clear_r <= 1'b0;
            s1_nan_r   <= 1'b0;
            s2_sum_r   <= 16'h0000;
            s2_valid_r <= 1'b0;
            s2_clear_r <= 1'b0;
            s2_nan_r   <= 1'b0;
            acc_r      <= 16'h0000;
            nan_r      <= 1'b0;
            c_out      <= 16'h0000;
            c_valid    <= 1'b0;
        end else begin
            a_out      <= a_in;
            b_out      <= b_in;
            fwd_valid  <= in_valid;
            for (int i = 0; i < NP; i++) begin
                s1_prod_r[i] <= mul_s[i][15:0];
            end
            s1_valid_r <= in_valid;
            s1_clear_r <= in_valid & clear;
            s1_nan_r   <= in_valid & prod_nan_s;
            s2_sum_r   <= node_s[0];
            s2_valid_r <= s1_valid_r;
            s2_clear_r <= s1_clear_r;
            s2_nan_r   <= s1_nan_r | tree_nan_s;
            if (s2_valid_r) begin
                acc_r <= acc_nxt_s;
                nan_r <= nan_nxt_s;
                c_out <= nan_nxt_s ? 16'h7FC0 : acc_nxt_s;
            end else begin
                acc_r <= acc_r;
                nan_r <= nan_r;
                c_out <= c_out;
            end
            c_valid    <= s2_valid_r;
        end
    end

endmodule

// File: tb/tb_pe_fp8_mac_pipe.sv
// Directed bench for pe_fp8_mac_pipe: a LANES=4 and a LANES=1 instance share stimulus
// (the single-lane one sees lane 0); expected BF16 values are hand-computed.
module tb_pe_fp8_mac_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        clear;
    logic        fmt;
    logic [31:0] a_in, b_in;
    logic [31:0] a_out4, b_out4;
    logic        fwd_valid4, c_valid4;
    logic [15:0] c_out4;
    logic [7:0]  a_out1, b_out1;
    logic        fwd_valid1, c_valid1;
    logic [15:0] c_out1;
    int          total;
    int          bad;

    pe_fp8_mac_pipe #(.LANES(4)) u_pe4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .fmt(fmt),
        .a_in(a_in), .b_in(b_in), .a_out(a_out4), .b_out(b_out4),
        .fwd_valid(fwd_valid4), .c_out(c_out4), .c_valid(c_valid4)
    );

    pe_fp8_mac_pipe #(.LANES(1)) u_pe1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .fmt(fmt),
        .a_in(a_in[7:0]), .b_in(b_in[7:0]), .a_out(a_out1), .b_out(b_out1),
        .fwd_valid(fwd_valid1), .c_out(c_out1), .c_valid(c_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One isolated beat: checks forwarding, 3-edge latency and both accumulators.
    task automatic run_beat(input string tag, input logic f, input logic [31:0] a,
                            input logic [31:0] b, input logic clr,
                            input logic [15:0] exp4, input logic [15:0] exp1);
        @(negedge clk);
        fmt = f; a_in = a; b_in = b; clear = clr; in_valid = 1'b1;
        @(negedge clk);
        check_eq({tag, "_fwd4"}, {31'd0, fwd_valid4}, 32'd1);
        check_eq({tag, "_aout4"}, a_out4, a);
        check_eq({tag, "_bout1"}, {24'd0, b_out1}, {24'd0, b[7:0]});
        in_valid = 1'b0; clear = 1'b0;
        check_eq({tag, "_cv_e0"}, {31'd0, c_valid4}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_fwd_off"}, {31'd0, fwd_valid1}, 32'd0);
        check_eq({tag, "_cv_e1"}, {31'd0, c_valid4}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_cv4"}, {31'd0, c_valid4}, 32'd1);
        check_eq({tag, "_cv1"}, {31'd0, c_valid1}, 32'd1);
        check_eq({tag, "_c4"}, {16'd0, c_out4}, {16'd0, exp4});
        check_eq({tag, "_c1"}, {16'd0, c_out1}, {16'd0, exp1});
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; fmt = 1'b0;
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check_eq("rst_aout", a_out4, 32'd0);
        check_eq("rst_fwd", {31'd0, fwd_valid4}, 32'd0);
        check_eq("rst_c", {16'd0, c_out4}, 32'd0);
        check_eq("rst_cv", {31'd0, c_valid1}, 32'd0);
        rst = 1'b0; a_in = 32'd0; b_in = 32'd0;

        run_beat("e4_1x2",  1'b0, 32'h38, 32'h40, 1'b1, 16'h4000, 16'h4000);
        run_beat("e4_acc",  1'b0, 32'h38, 32'h40, 1'b0, 16'h4080, 16'h4080);
        run_beat("e5_1p5",  1'b1, 32'h3C, 32'h3E, 1'b1, 16'h3FC0, 16'h3FC0);
        run_beat("e5_canc", 1'b1, 32'hBC, 32'h3E, 1'b0, 16'h0000, 16'h0000);

        run_beat("l4_ones", 1'b0, 32'h3838_3838, 32'h3838_3838, 1'b1, 16'h4080, 16'h3F80);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bub_cv", {31'd0, c_valid4}, 32'd0);
            check_eq("bub_hold", {16'd0, c_out4}, 32'h4080);
        end
        run_beat("l4_mix",  1'b0, 32'h4038_3838, 32'h3838_3838, 1'b1, 16'h40A0, 16'h3F80);

        run_beat("rne_256", 1'b0, 32'h58, 32'h58, 1'b1, 16'h4380, 16'h4380);
        run_beat("rne_tie", 1'b0, 32'h38, 32'h38, 1'b0, 16'h4380, 16'h4380);
        run_beat("rne_up",  1'b0, 32'h38, 32'h44, 1'b0, 16'h4382, 16'h4382);

        run_beat("nan_pre", 1'b0, 32'h38, 32'h38, 1'b1, 16'h3F80, 16'h3F80);
        run_beat("nan_in",  1'b0, 32'h7F, 32'h38, 1'b0, 16'h7FC0, 16'h7FC0);
        run_beat("nan_stk", 1'b0, 32'h38, 32'h38, 1'b0, 16'h7FC0, 16'h7FC0);
        run_beat("nan_clr", 1'b0, 32'h38, 32'h38, 1'b1, 16'h3F80, 16'h3F80);
        run_beat("inf_e5",  1'b1, 32'h7C, 32'h3C, 1'b1, 16'h7F80, 16'h7F80);
        run_beat("inf_fin", 1'b1, 32'h3C, 32'h3C, 1'b0, 16'h7F80, 16'h7F80);
        run_beat("inf_ninf",1'b1, 32'hFC, 32'h3C, 1'b0, 16'h7FC0, 16'h7FC0);
        run_beat("inf_x0",  1'b1, 32'h7C, 32'h00, 1'b1, 16'h7FC0, 16'h7FC0);
        run_beat("rec_clr", 1'b0, 32'h38, 32'h38, 1'b1, 16'h3F80, 16'h3F80);

        // clear without in_valid must not start a new sum
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b0; a_in = 32'h40; b_in = 32'h40;
        run_beat("ign_clr", 1'b0, 32'h38, 32'h38, 1'b0, 16'h4000, 16'h4000);

        // back-to-back beats: 1, then +2, then +1
        @(negedge clk);
        fmt = 1'b0; in_valid = 1'b1; clear = 1'b1; a_in = 32'h38; b_in = 32'h38;
        @(negedge clk);
        clear = 1'b0; a_in = 32'h40;
        @(negedge clk);
        a_in = 32'h38;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("tp_cv0", {31'd0, c_valid4}, 32'd1);
        check_eq("tp_c0", {16'd0, c_out4}, 32'h3F80);
        @(negedge clk);
        check_eq("tp_cv1", {31'd0, c_valid1}, 32'd1);
        check_eq("tp_c1", {16'd0, c_out1}, 32'h4040);
        @(negedge clk);
        check_eq("tp_c2", {16'd0, c_out4}, 32'h4080);
        @(negedge clk);
        check_eq("tp_cv3", {31'd0, c_valid4}, 32'd0);

        // asynchronous reset with beats in flight
        @(negedge clk);
        in_valid = 1'b1; clear = 1'b1; a_in = 32'h3838_3838; b_in = 32'h3838_3838;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_aout", a_out4, 32'd0);
        check_eq("ar_fwd", {31'd0, fwd_valid4}, 32'd0);
        check_eq("ar_c4", {16'd0, c_out4}, 32'd0);
        check_eq("ar_cv4", {31'd0, c_valid4}, 32'd0);
        check_eq("ar_c1", {16'd0, c_out1}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("ar_stale4", {31'd0, c_valid4}, 32'd0);
            check_eq("ar_stale1", {31'd0, c_valid1}, 32'd0);
        end
        run_beat("post_rst", 1'b0, 32'h38, 32'h38, 1'b0, 16'h3F80, 16'h3F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
